cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 42 ++++
 rtl/cdb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundles the global enable, flush, both producer ports and
// the common-data-bus broadcast of cdb_arbiter.
// master = environment side (producers, pipeline control, bus consumer).
// slave  = arbiter side.
// Handshake: a producer offers an entry by raising *_valid for one cycle.
// The entry is taken on that posedge only if rdy=1, flush=0 and the matching
// *_full was 0 during the cycle. There is no back-pressure beyond *_full, so
// an offer made while full is lost and producers must watch *_full.
// The broadcast side has no ready input: cdb_ready=1 marks a single-cycle
// broadcast of cdb_id/cdb_val/cdb_src.
interface cdb_arbiter_if;
  logic        rdy;
  logic        flush;
  logic        alu_valid;
  logic [3:0]  alu_id;
  logic [31:0] alu_res;
  logic        mem_valid;
  logic [3:0]  mem_id;
  logic [31:0] mem_data;
  logic        alu_full;
  logic        mem_full;
  logic        cdb_ready;
  logic [3:0]  cdb_id;
  logic [31:0] cdb_val;
  logic        cdb_src;

  modport master (
    output rdy, flush,
    output alu_valid, alu_id, alu_res,
    output mem_valid, mem_id, mem_data,
    input  alu_full, mem_full,
    input  cdb_ready, cdb_id, cdb_val, cdb_src
  );

  modport slave (
    input  rdy, flush,
    input  alu_valid, alu_id, alu_res,
    input  mem_valid, mem_id, mem_data,
    output alu_full, mem_full,
    output cdb_ready, cdb_id, cdb_val, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two small result FIFOs (ALU, memory) that share one
// common-data-bus broadcast slot. At most one entry is broadcast per enabled
// cycle. The broadcast registers are loaded one cycle after the pop decision,
// so the minimum push-to-broadcast latency is two cycles.
// Build option: define CDB_ROUND_ROBIN_EN to alternate sources when both
// FIFOs hold entries. Without it, memory always wins over ALU.
// Debug outputs expose the last-grant bit and both occupancy counts.
module cdb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus,
  output logic          last_grant_o,
  output logic [2:0]    alu_count_o,
  output logic [2:0]    mem_count_o
);

  // Pointer width covers DEPTH of 2 or 4. Counts are 3 bits so they can hold DEPTH.
  localparam int             PW       = (DEPTH > 2) ? 2 : 1;
  localparam logic [PW-1:0]  LAST_IDX = PW'(DEPTH - 1);
  localparam logic [2:0]     FULL_CNT = 3'(DEPTH);

  // Entry storage: {id, value}
  logic [35:0]   alu_buf_q [DEPTH];
  logic [35:0]   mem_buf_q [DEPTH];

  logic [PW-1:0] alu_head_q, alu_head_d, alu_tail_q, alu_tail_d;
  logic [PW-1:0] mem_head_q, mem_head_d, mem_tail_q, mem_tail_d;
  logic [2:0]    alu_cnt_q, alu_cnt_d, mem_cnt_q, mem_cnt_d;
  logic          last_grant_q, last_grant_d;   // 0 = ALU, 1 = memory

  logic          cdb_ready_q, cdb_ready_d;
  logic [3:0]    cdb_id_q, cdb_id_d;
  logic [31:0]   cdb_val_q, cdb_val_d;
  logic          cdb_src_q, cdb_src_d;

  logic          active;
  logic          alu_ne, mem_ne;
  logic          grant_mem;
  logic          any_pop, alu_pop, mem_pop;
  logic          alu_push, mem_push;
  logic [35:0]   pop_entry;

  // Circular pointer advance with explicit wrap at the last slot.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // Full flags come only from registered counts: a pop this cycle never frees a slot for a push this cycle.
  assign bus.alu_full = (alu_cnt_q == FULL_CNT);
  assign bus.mem_full = (mem_cnt_q == FULL_CNT);

  assign bus.cdb_ready = cdb_ready_q;
  assign bus.cdb_id    = cdb_id_q;
  assign bus.cdb_val   = cdb_val_q;
  assign bus.cdb_src   = cdb_src_q;

  assign last_grant_o  = last_grant_q;
  assign alu_count_o   = alu_cnt_q;
  assign mem_count_o   = mem_cnt_q;

  // Arbitration and push/pop qualification.
  always_comb begin
    active = bus.rdy && !bus.flush;
    alu_ne = (alu_cnt_q != 3'd0);
    mem_ne = (mem_cnt_q != 3'd0);
`ifdef CDB_ROUND_ROBIN_EN
    // When both sources have entries, grant the one that did not win last time.
    grant_mem = mem_ne && (!alu_ne || !last_grant_q);
`else
    // Fixed priority: memory wins whenever it has an entry.
    grant_mem = mem_ne;
`endif
    any_pop   = active && (alu_ne || mem_ne);
    mem_pop   = any_pop && grant_mem;
    alu_pop   = any_pop && !grant_mem;
    alu_push  = active && bus.alu_valid && !bus.alu_full;
    mem_push  = active && bus.mem_valid && !bus.mem_full;
    pop_entry = grant_mem ? mem_buf_q[mem_head_q] : alu_buf_q[alu_head_q];
  end

  // Next-state for pointers, counts, last-grant and the broadcast registers.
  always_comb begin
    alu_head_d   = alu_head_q;
    alu_tail_d   = alu_tail_q;
    alu_cnt_d    = alu_cnt_q;
    mem_head_d   = mem_head_q;
    mem_tail_d   = mem_tail_q;
    mem_cnt_d    = mem_cnt_q;
    last_grant_d = last_grant_q;
    cdb_ready_d  = cdb_ready_q;
    cdb_id_d     = cdb_id_q;
    cdb_val_d    = cdb_val_q;
    cdb_src_d    = cdb_src_q;

    if (bus.rdy) begin
      if (bus.flush) begin
        // Flush empties both queues and cancels the broadcast. Last-grant is kept.
        alu_head_d  = '0;
        alu_tail_d  = '0;
        alu_cnt_d   = 3'd0;
        mem_head_d  = '0;
        mem_tail_d  = '0;
        mem_cnt_d   = 3'd0;
        cdb_ready_d = 1'b0;
      end else begin
        if (alu_push) alu_tail_d = next_ptr(alu_tail_q);
        if (alu_pop)  alu_head_d = next_ptr(alu_head_q);
        if (mem_push) mem_tail_d = next_ptr(mem_tail_q);
        if (mem_pop)  mem_head_d = next_ptr(mem_head_q);
        alu_cnt_d = alu_cnt_q + {2'b00, alu_push} - {2'b00, alu_pop};
        mem_cnt_d = mem_cnt_q + {2'b00, mem_push} - {2'b00, mem_pop};

        cdb_ready_d = any_pop;
        if (any_pop) begin
          last_grant_d = grant_mem;
          cdb_id_d     = pop_entry[35:32];
          cdb_val_d    = pop_entry[31:0];
          cdb_src_d    = grant_mem;
        end
      end
    end
  end

  // State registers. Reset wins over flush and over the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_head_q   <= '0;
      alu_tail_q   <= '0;
      alu_cnt_q    <= 3'd0;
      mem_head_q   <= '0;
      mem_tail_q   <= '0;
      mem_cnt_q    <= 3'd0;
      last_grant_q <= 1'b0;
      cdb_ready_q  <= 1'b0;
      cdb_id_q     <= 4'd0;
      cdb_val_q    <= 32'd0;
      cdb_src_q    <= 1'b0;
    end else begin
      alu_head_q   <= alu_head_d;
      alu_tail_q   <= alu_tail_d;
      alu_cnt_q    <= alu_cnt_d;
      mem_head_q   <= mem_head_d;
      mem_tail_q   <= mem_tail_d;
      mem_cnt_q    <= mem_cnt_d;
      last_grant_q <= last_grant_d;
      cdb_ready_q  <= cdb_ready_d;
      cdb_id_q     <= cdb_id_d;
      cdb_val_q    <= cdb_val_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  // Entry storage. No reset is needed because the counts gate every read.
  always_ff @(posedge clk) begin
    if (alu_push && !rst) alu_buf_q[alu_tail_q] <= {bus.alu_id, bus.alu_res};
    if (mem_push && !rst) mem_buf_q[mem_tail_q] <= {bus.mem_id, bus.mem_data};
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter (DEPTH=2). Accepted pushes
// are queued per source as {src, id, value}. Every broadcast is popped and
// compared against the queue for its source. Directed checks pin down timing,
// arbitration order, full behaviour, flush, enable stall and reset.
// The checks that depend on arbitration follow CDB_ROUND_ROBIN_EN.
module tb_cdb_arbiter;

  logic clk;
  logic rst;
  logic last_grant;
  logic [2:0] alu_count;
  logic [2:0] mem_count;

  cdb_arbiter_if bus ();

  cdb_arbiter #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .last_grant_o (last_grant),
    .alu_count_o  (alu_count),
    .mem_count_o  (mem_count)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [36:0] alu_exp_q[$];
  logic [36:0] mem_exp_q[$];
  logic [36:0] mon_got, mon_exp;

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Compare helper.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks. Inputs change #1 after a posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [3:0] id, input logic [31:0] val, input bit accept);
    bus.alu_valid = 1'b1;
    bus.alu_id    = id;
    bus.alu_res   = val;
    if (accept) alu_exp_q.push_back({1'b0, id, val});
  endtask

  task automatic drive_mem(input logic [3:0] id, input logic [31:0] val, input bit accept);
    bus.mem_valid = 1'b1;
    bus.mem_id    = id;
    bus.mem_data  = val;
    if (accept) mem_exp_q.push_back({1'b1, id, val});
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (alu_exp_q.size() != 0 || mem_exp_q.size() != 0); k++) tick();
    chk("drain_alu_queue", 64'(alu_exp_q.size()), 64'd0);
    chk("drain_mem_queue", 64'(mem_exp_q.size()), 64'd0);
  endtask

  // Scoreboard: each broadcast must match the oldest accepted entry of its source.
  always @(negedge clk) begin
    if (!rst && bus.cdb_ready) begin
      mon_got = {bus.cdb_src, bus.cdb_id, bus.cdb_val};
      if (bus.cdb_src) begin
        vectors++;
        assert (mem_exp_q.size() > 0) else begin
          miscompares++;
          $error("FAIL mon_unexpected_mem: got %0h want no broadcast", mon_got);
        end
        if (mem_exp_q.size() > 0) begin
          mon_exp = mem_exp_q.pop_front();
          chk("mon_mem_entry", 64'(mon_got), 64'(mon_exp));
        end
      end else begin
        vectors++;
        assert (alu_exp_q.size() > 0) else begin
          miscompares++;
          $error("FAIL mon_unexpected_alu: got %0h want no broadcast", mon_got);
        end
        if (alu_exp_q.size() > 0) begin
          mon_exp = alu_exp_q.pop_front();
          chk("mon_alu_entry", 64'(mon_got), 64'(mon_exp));
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    logic [31:0] rv;
    rst           = 1'b1;
    bus.rdy       = 1'b1;
    bus.flush     = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_id    = 4'd0;
    bus.alu_res   = 32'd0;
    bus.mem_valid = 1'b0;
    bus.mem_id    = 4'd0;
    bus.mem_data  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    chk("rst_cdb_ready", bus.cdb_ready, 0);
    chk("rst_cdb_id", bus.cdb_id, 0);
    chk("rst_cdb_val", bus.cdb_val, 0);
    chk("rst_cdb_src", bus.cdb_src, 0);
    chk("rst_alu_full", bus.alu_full, 0);
    chk("rst_mem_full", bus.mem_full, 0);
    chk("rst_last_grant", last_grant, 0);
    chk("rst_alu_count", alu_count, 0);
    chk("rst_mem_count", mem_count, 0);

    // Single ALU result: broadcast two cycles after the push.
    drive_alu(4'd3, 32'h11, 1'b1);
    tick(); idle();
    chk("t1_alu_count", alu_count, 1);
    chk("t1_no_early_bcast", bus.cdb_ready, 0);
    tick();
    chk("t1_ready", bus.cdb_ready, 1);
    chk("t1_id", bus.cdb_id, 3);
    chk("t1_val", bus.cdb_val, 32'h11);
    chk("t1_src", bus.cdb_src, 0);
    tick();
    chk("t1_ready_drop", bus.cdb_ready, 0);
    chk("t1_id_hold", bus.cdb_id, 3);

    // Simultaneous ALU and memory push. Memory goes first in both builds.
    drive_alu(4'd1, 32'hA, 1'b1);
    drive_mem(4'd2, 32'hB, 1'b1);
    tick(); idle();
    tick();
    chk("t2_first_src", bus.cdb_src, 1);
    chk("t2_first_id", bus.cdb_id, 2);
    tick();
    chk("t2_second_src", bus.cdb_src, 0);
    chk("t2_second_id", bus.cdb_id, 1);
    chk("t2_second_val", bus.cdb_val, 32'hA);
    tick();
    chk("t2_idle", bus.cdb_ready, 0);

`ifndef CDB_ROUND_ROBIN_EN
    // Memory busy every cycle: the ALU FIFO fills, the third ALU value is dropped, and ALU drains last.
    rv = $urandom_range(32'hFFFF, 0);
    drive_alu(4'd4, rv, 1'b1); drive_mem(4'd8, rv + 32'd1, 1'b1);
    tick();
    chk("t3_alu_not_full", bus.alu_full, 0);
    drive_alu(4'd5, rv + 32'd2, 1'b1); drive_mem(4'd9, rv + 32'd3, 1'b1);
    tick();
    chk("t3_alu_full", bus.alu_full, 1);
    chk("t3_bcast_m8", {bus.cdb_ready, bus.cdb_src, bus.cdb_id}, {1'b1, 1'b1, 4'd8});
    drive_alu(4'd6, rv + 32'd4, 1'b0); drive_mem(4'd10, rv + 32'd5, 1'b1);
    tick(); idle();
    chk("t3_drop_count", alu_count, 2);
    chk("t3_bcast_m9", {bus.cdb_src, bus.cdb_id}, {1'b1, 4'd9});
    tick();
    chk("t3_bcast_m10", {bus.cdb_src, bus.cdb_id}, {1'b1, 4'd10});
    tick();
    chk("t3_bcast_a4", {bus.cdb_src, bus.cdb_id}, {1'b0, 4'd4});
    tick();
    chk("t3_bcast_a5", {bus.cdb_src, bus.cdb_id}, {1'b0, 4'd5});
    chk("t3_alu_empty", alu_count, 0);
    tick();
    chk("t3_idle", bus.cdb_ready, 0);
`endif

    // Flush with two entries queued. Last-grant is set to 1 first.
    drive_mem(4'd7, 32'h77, 1'b1);
    tick(); idle();
    tick();
    chk("t4_pre_id", bus.cdb_id, 7);
    chk("t4_pre_last", last_grant, 1);
    drive_alu(4'd12, 32'hC12, 1'b0); drive_mem(4'd13, 32'hD13, 1'b0);
    tick(); idle();
    chk("t4_queued", {alu_count, mem_count}, {3'd1, 3'd1});
    bus.flush = 1'b1;
    drive_alu(4'd14, 32'hE14, 1'b0);
    tick();
    bus.flush = 1'b0; idle();
    chk("t4_ready", bus.cdb_ready, 0);
    chk("t4_counts", {alu_count, mem_count}, 6'd0);
    chk("t4_last_kept", last_grant, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_late_bcast", bus.cdb_ready, 0);
    end

    // Enable low for three cycles after an ALU push.
    drive_alu(4'd15, 32'h5A, 1'b1);
    tick(); idle();
    bus.rdy = 1'b0;
    drive_mem(4'd3, 32'h33, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stall_ready", bus.cdb_ready, 0);
      chk("t5_stall_id", bus.cdb_id, 7);
      chk("t5_stall_counts", {alu_count, mem_count}, {3'd1, 3'd0});
      chk("t5_stall_last", last_grant, 1);
    end
    bus.rdy = 1'b1; idle();
    tick();
    chk("t5_bcast", {bus.cdb_ready, bus.cdb_src, bus.cdb_id, bus.cdb_val}, {1'b1, 1'b0, 4'd15, 32'h5A});
    tick();
    chk("t5_idle", bus.cdb_ready, 0);

`ifdef CDB_ROUND_ROBIN_EN
    // Both sources kept busy. Grants alternate memory/ALU starting with memory.
    rv = $urandom_range(32'hFFFF, 0);
    drive_alu(4'd0, rv, 1'b1); drive_mem(4'd1, rv + 32'd1, 1'b1);
    tick();
    drive_alu(4'd2, rv + 32'd2, 1'b1); drive_mem(4'd3, rv + 32'd3, 1'b1);
    tick();
    chk("t6_src_0", {bus.cdb_ready, bus.cdb_src}, 2'b11);
    for (int i = 1; i < 6; i++) begin
      idle();
      if (i % 2 == 1) drive_mem(4'(4 + i), rv + 32'(i), 1'b1);
      else            drive_alu(4'(4 + i), rv + 32'(i), 1'b1);
      tick();
      chk("t6_src_alt", {bus.cdb_ready, bus.cdb_src}, {1'b1, (i % 2 == 0) ? 1'b1 : 1'b0});
    end
    idle();
`endif
    drain();

    // Reset mid-operation, asserted together with flush.
    drive_mem(4'd5, 32'h55, 1'b1);
    tick(); idle();
    tick();
    chk("t7_pre_last", last_grant, 1);
    chk("t7_pre_id", bus.cdb_id, 5);
    drive_alu(4'd6, 32'h66, 1'b0); drive_mem(4'd9, 32'h99, 1'b0);
    tick(); idle();
    rst = 1'b1; bus.flush = 1'b1;
    tick();
    rst = 1'b0; bus.flush = 1'b0;
    chk("t7_ready", bus.cdb_ready, 0);
    chk("t7_id_val_src", {bus.cdb_id, bus.cdb_val, bus.cdb_src}, 37'd0);
    chk("t7_last", last_grant, 0);
    chk("t7_counts", {alu_count, mem_count}, 6'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_no_bcast", bus.cdb_ready, 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
